rs_age_multi_cdb: RTL and testbench

//  Parametrised ALU reservation station: buffers decoded I/R/B-type ops until operands are ready, then issues one per cycle to the ALU.

---
 rtl/rs_age_multi_cdb_pkg.sv | 18 +
 rtl/rs_age_multi_cdb_age_select.sv | 29 ++
 rtl/rs_age_multi_cdb.sv | 229 ++++++++++++++++++++++
 tb/tb_rs_age_multi_cdb.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_age_multi_cdb_pkg.sv
// Shared constants for the multi-CDB ALU reservation station: default sizes,
// CDB port indices and the opcode classes the station is fed.
package rs_age_multi_cdb_pkg;

  localparam int ROB_SIZE_WIDTH = 4;
  localparam int RS_SIZE        = 8;

  // Broadcast port assignment on the packed CDB inputs
  localparam int CDB_ALU = 0;
  localparam int CDB_LSB = 1;

  typedef enum logic [6:0] {
    OPC_I = 7'b0010011,
    OPC_R = 7'b0110011,
    OPC_B = 7'b1100011
  } opc_e;

endpackage

// File: rtl/rs_age_multi_cdb_age_select.sv
// Oldest-first selector: given a ready vector and an age matrix
// (age[i][j]=1 means entry i is older than entry j), returns a one-hot grant
// for the oldest ready entry plus an any-ready flag.
module rs_age_select
  import rs_age_multi_cdb_pkg::*;
#(
  parameter int N = RS_SIZE
) (
  input  logic [N-1:0]        ready,
  input  logic [N-1:0][N-1:0] age,
  output logic [N-1:0]        grant,
  output logic                any
);

  // An entry wins when no other ready entry is older than it
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = ready[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && ready[j] && age[j][i]) grant[i] = 1'b0;
      end
    end
  end

  assign any = |ready;

endmodule

// File: rtl/rs_age_multi_cdb.sv
// ALU reservation station with configurable depth, NUM_CDB broadcast ports,
// oldest-first issue and a valid/ready issue handshake.
// Optional feature macro: RS_WAKE_BYPASS_EN -- when defined, an entry whose
// last pending operand(s) match a CDB this cycle may issue in the same cycle,
// taking the broadcast value combinationally.
module rs_age_multi_cdb
  import rs_age_multi_cdb_pkg::*;
#(
  parameter int RS_DEPTH = RS_SIZE,
  parameter int ROB_ID_W = ROB_SIZE_WIDTH,
  parameter int NUM_CDB  = 2,
  parameter int XLEN     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         flush,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [31:0]                  disp_instr,
  input  logic [2:0]                   disp_op,
  input  logic [6:0]                   disp_type,
  input  logic [XLEN-1:0]              disp_v1,
  input  logic [XLEN-1:0]              disp_v2,
  input  logic                         disp_dep1,
  input  logic                         disp_dep2,
  input  logic [ROB_ID_W-1:0]          disp_tag1,
  input  logic [ROB_ID_W-1:0]          disp_tag2,
  input  logic [ROB_ID_W-1:0]          disp_rob_id,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*ROB_ID_W-1:0]  cdb_rob_id,
  input  logic [NUM_CDB*XLEN-1:0]      cdb_value,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [ROB_ID_W-1:0]          issue_rob_id,
  output logic [2:0]                   issue_op,
  output logic [6:0]                   issue_type,
  output logic                         issue_other,
  output logic [XLEN-1:0]              issue_v1,
  output logic [XLEN-1:0]              issue_v2,
  output logic [$clog2(RS_DEPTH):0]    count
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  // Entry state
  logic [RS_DEPTH-1:0]                busy_q, dep1_q, dep2_q, other_q;
  logic [ROB_ID_W-1:0]                tag1_q [RS_DEPTH];
  logic [ROB_ID_W-1:0]                tag2_q [RS_DEPTH];
  logic [ROB_ID_W-1:0]                rob_q  [RS_DEPTH];
  logic [XLEN-1:0]                    v1_q   [RS_DEPTH];
  logic [XLEN-1:0]                    v2_q   [RS_DEPTH];
  logic [2:0]                         op_q   [RS_DEPTH];
  logic [6:0]                         type_q [RS_DEPTH];
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0]  age_q;
  logic [CNT_W-1:0]                   count_q;

  // Unpacked CDB view and match results
  logic [ROB_ID_W-1:0]  cdb_tag [NUM_CDB];
  logic [XLEN-1:0]      cdb_val [NUM_CDB];
  logic [RS_DEPTH-1:0]  hit1, hit2;
  logic [XLEN-1:0]      wval1 [RS_DEPTH];
  logic [XLEN-1:0]      wval2 [RS_DEPTH];
  logic                 dhit1, dhit2;
  logic [XLEN-1:0]      dval1, dval2;

  logic [RS_DEPTH-1:0]  ready_vec, grant;
  logic                 any_ready;
  logic [IDX_W-1:0]     free_idx;
  logic                 accept, fire;

  // Only bit 30 of the raw instruction is carried through the station
  logic unused_instr_bits;
  assign unused_instr_bits = ^{disp_instr[31], disp_instr[29:0]};

  // Split the packed broadcast buses into per-port tag/value
  always_comb begin
    for (int k = 0; k < NUM_CDB; k++) begin
      cdb_tag[k] = cdb_rob_id[k*ROB_ID_W +: ROB_ID_W];
      cdb_val[k] = cdb_value[k*XLEN +: XLEN];
    end
  end

  // Per-entry wake-up match; scanning high to low lets the lowest port win
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      hit1[i]  = 1'b0;
      hit2[i]  = 1'b0;
      wval1[i] = '0;
      wval2[i] = '0;
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
        if (busy_q[i] && dep1_q[i] && cdb_valid[k] && cdb_tag[k] == tag1_q[i]) begin
          hit1[i]  = 1'b1;
          wval1[i] = cdb_val[k];
        end
        if (busy_q[i] && dep2_q[i] && cdb_valid[k] && cdb_tag[k] == tag2_q[i]) begin
          hit2[i]  = 1'b1;
          wval2[i] = cdb_val[k];
        end
      end
    end
  end

  // Same-cycle capture for the op being dispatched, so no wake-up is lost
  always_comb begin
    dhit1 = 1'b0;
    dhit2 = 1'b0;
    dval1 = '0;
    dval2 = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (disp_dep1 && cdb_valid[k] && cdb_tag[k] == disp_tag1) begin
        dhit1 = 1'b1;
        dval1 = cdb_val[k];
      end
      if (disp_dep2 && cdb_valid[k] && cdb_tag[k] == disp_tag2) begin
        dhit2 = 1'b1;
        dval2 = cdb_val[k];
      end
    end
  end

`ifdef RS_WAKE_BYPASS_EN
  assign ready_vec = busy_q & (~dep1_q | hit1) & (~dep2_q | hit2);
`else
  assign ready_vec = busy_q & ~dep1_q & ~dep2_q;
`endif

  rs_age_select #(.N(RS_DEPTH)) u_age_select (
    .ready (ready_vec),
    .age   (age_q),
    .grant (grant),
    .any   (any_ready)
  );

  // Lowest-index free slot from registered busy (no same-cycle lookahead)
  always_comb begin
    free_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
    end
  end

  assign disp_ready  = rdy && (count_q != CNT_W'(RS_DEPTH));
  assign issue_valid = rdy && any_ready;
  assign accept      = disp_valid && disp_ready;
  assign fire        = issue_valid && issue_ready;
  assign count       = count_q;

  // One-hot mux of the granted entry onto the issue port
  always_comb begin
    issue_rob_id = '0;
    issue_op     = '0;
    issue_type   = '0;
    issue_other  = 1'b0;
    issue_v1     = '0;
    issue_v2     = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (grant[i]) begin
        issue_rob_id = rob_q[i];
        issue_op     = op_q[i];
        issue_type   = type_q[i];
        issue_other  = other_q[i];
`ifdef RS_WAKE_BYPASS_EN
        issue_v1     = hit1[i] ? wval1[i] : v1_q[i];
        issue_v2     = hit2[i] ? wval2[i] : v2_q[i];
`else
        issue_v1     = v1_q[i];
        issue_v2     = v2_q[i];
`endif
      end
    end
  end

  // Entry, age-matrix and occupancy update: clear, wake-up, free, dispatch
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every read sees pre-edge values.
    if (rst || flush) begin
      busy_q  <= '0;
      dep1_q  <= '0;
      dep2_q  <= '0;
      other_q <= '0;
      age_q   <= '0;
      count_q <= '0;
      // NOTE: payload arrays are cleared too, so issue outputs never show stale data after reset.
      for (int i = 0; i < RS_DEPTH; i++) begin
        tag1_q[i] <= '0;
        tag2_q[i] <= '0;
        rob_q[i]  <= '0;
        v1_q[i]   <= '0;
        v2_q[i]   <= '0;
        op_q[i]   <= '0;
        type_q[i] <= '0;
      end
    end else if (rdy) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (hit1[i]) begin
          dep1_q[i] <= 1'b0;
          v1_q[i]   <= wval1[i];
        end
        if (hit2[i]) begin
          dep2_q[i] <= 1'b0;
          v2_q[i]   <= wval2[i];
        end
        if (fire && grant[i]) busy_q[i] <= 1'b0;
      end
      if (accept) begin
        busy_q[free_idx]  <= 1'b1;
        dep1_q[free_idx]  <= disp_dep1 && !dhit1;
        dep2_q[free_idx]  <= disp_dep2 && !dhit2;
        v1_q[free_idx]    <= dhit1 ? dval1 : disp_v1;
        v2_q[free_idx]    <= dhit2 ? dval2 : disp_v2;
        tag1_q[free_idx]  <= disp_tag1;
        tag2_q[free_idx]  <= disp_tag2;
        rob_q[free_idx]   <= disp_rob_id;
        op_q[free_idx]    <= disp_op;
        type_q[free_idx]  <= disp_type;
        other_q[free_idx] <= disp_instr[30];
        // New entry is younger than everything already resident
        age_q[free_idx] <= '0;
        for (int j = 0; j < RS_DEPTH; j++) begin
          age_q[j][free_idx] <= busy_q[j];
        end
      end
      count_q <= count_q + CNT_W'(accept) - CNT_W'(fire);
    end
  end

endmodule

// File: tb/tb_rs_age_multi_cdb.sv
// Directed self-checking bench for rs_age_multi_cdb (default parameters).
// Expectations for the same-cycle wake-up cases follow RS_WAKE_BYPASS_EN.
module tb_rs_age_multi_cdb;
  import rs_age_multi_cdb_pkg::*;

  localparam int RW = 4;
  localparam int XL = 32;
  localparam int NC = 2;

  logic               clk = 1'b0;
  logic               rst, rdy, flush;
  logic               disp_valid, disp_ready;
  logic [31:0]        disp_instr;
  logic [2:0]         disp_op;
  logic [6:0]         disp_type;
  logic [XL-1:0]      disp_v1, disp_v2;
  logic               disp_dep1, disp_dep2;
  logic [RW-1:0]      disp_tag1, disp_tag2, disp_rob_id;
  logic [NC-1:0]      cdb_valid;
  logic [NC*RW-1:0]   cdb_rob_id;
  logic [NC*XL-1:0]   cdb_value;
  logic               issue_valid, issue_ready;
  logic [RW-1:0]      issue_rob_id;
  logic [2:0]         issue_op;
  logic [6:0]         issue_type;
  logic               issue_other;
  logic [XL-1:0]      issue_v1, issue_v2;
  logic [3:0]         count;

  int errors = 0;
  int checks = 0;

  rs_age_multi_cdb dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .flush        (flush),
    .disp_valid   (disp_valid),
    .disp_ready   (disp_ready),
    .disp_instr   (disp_instr),
    .disp_op      (disp_op),
    .disp_type    (disp_type),
    .disp_v1      (disp_v1),
    .disp_v2      (disp_v2),
    .disp_dep1    (disp_dep1),
    .disp_dep2    (disp_dep2),
    .disp_tag1    (disp_tag1),
    .disp_tag2    (disp_tag2),
    .disp_rob_id  (disp_rob_id),
    .cdb_valid    (cdb_valid),
    .cdb_rob_id   (cdb_rob_id),
    .cdb_value    (cdb_value),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_rob_id (issue_rob_id),
    .issue_op     (issue_op),
    .issue_type   (issue_type),
    .issue_other  (issue_other),
    .issue_v1     (issue_v1),
    .issue_v2     (issue_v2),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    disp_instr = '0;
    disp_op    = '0;
    disp_type  = '0;
    disp_v1    = '0;
    disp_v2    = '0;
    disp_dep1  = 1'b0;
    disp_dep2  = 1'b0;
    disp_tag1  = '0;
    disp_tag2  = '0;
    disp_rob_id = '0;
    cdb_valid  = '0;
    cdb_rob_id = '0;
    cdb_value  = '0;
  endtask

  // op = rob[2:0], instr bit 30 = rob[0], type = R
  task automatic disp(input logic [3:0] rob, input logic [31:0] v1, input logic [31:0] v2,
                      input logic d1, input logic [3:0] t1, input logic d2, input logic [3:0] t2);
    disp_valid  = 1'b1;
    disp_rob_id = rob;
    disp_v1     = v1;
    disp_v2     = v2;
    disp_dep1   = d1;
    disp_tag1   = t1;
    disp_dep2   = d2;
    disp_tag2   = t2;
    disp_op     = rob[2:0];
    disp_type   = OPC_R;
    disp_instr  = {1'b0, rob[0], 30'h0};
  endtask

  task automatic cdb(input int k, input logic [3:0] tag, input logic [31:0] val);
    cdb_valid[k]           = 1'b1;
    cdb_rob_id[k*RW +: RW] = tag;
    cdb_value[k*XL +: XL]  = val;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    rdy = 1'b1; rst = 1'b1; flush = 1'b0; issue_ready = 1'b0;
    idle();
    tick(); tick();
    rst = 1'b0; #1;
    check("reset_count", 64'(count), 0);
    check("reset_disp_ready", 64'(disp_ready), 1);
    check("reset_issue_valid", 64'(issue_valid), 0);

    // Fill all 8 slots with ready ops while the ALU stalls
    for (int i = 0; i < 8; i++) begin
      disp(4'(i), 32'h100 + i, 32'h200 + i, 1'b0, 4'd0, 1'b0, 4'd0); #1;
      check("fill_disp_ready", 64'(disp_ready), 1);
      tick();
    end
    idle(); #1;
    check("full_count", 64'(count), 8);
    check("full_disp_ready", 64'(disp_ready), 0);
    check("full_issue_valid", 64'(issue_valid), 1);
    check("full_oldest_rob", 64'(issue_rob_id), 0);
    check("full_oldest_v1", 64'(issue_v1), 64'h100);
    disp(4'd9, 32'h999, 32'h999, 1'b0, 4'd0, 1'b0, 4'd0); #1;
    check("ninth_disp_ready", 64'(disp_ready), 0);
    tick(); idle(); #1;
    check("ninth_ignored_count", 64'(count), 8);

    // Backpressure: outputs stay put while issue_ready=0
    for (int c = 0; c < 3; c++) begin
      tick();
      check("hold_valid", 64'(issue_valid), 1);
      check("hold_rob", 64'(issue_rob_id), 0);
      check("hold_v2", 64'(issue_v2), 64'h200);
    end

    // Drain in dispatch order
    issue_ready = 1'b1; #1;
    for (int i = 0; i < 8; i++) begin
      check("drain_rob", 64'(issue_rob_id), 64'(i));
      check("drain_v2", 64'(issue_v2), 64'h200 + 64'(i));
      tick();
    end
    issue_ready = 1'b0; #1;
    check("drain_count", 64'(count), 0);
    check("drain_valid", 64'(issue_valid), 0);

    // Oldest-first: A waits on tag 1, B ready; CDB0 wakes A while B issues
    disp(4'd3, 32'h0, 32'h22, 1'b1, 4'd1, 1'b0, 4'd0); tick();
    disp(4'd5, 32'h55, 32'h66, 1'b0, 4'd1, 1'b0, 4'd0); #1;
    check("a_not_ready", 64'(issue_valid), 0);
    tick();
    idle();
    disp(4'd7, 32'h77, 32'h88, 1'b0, 4'd1, 1'b0, 4'd0);
    cdb(0, 4'd1, 32'h10);
    issue_ready = 1'b1; #1;
    check("order1_valid", 64'(issue_valid), 1);
`ifdef RS_WAKE_BYPASS_EN
    check("order1_rob", 64'(issue_rob_id), 3);
    check("order1_v1", 64'(issue_v1), 64'h10);
    check("order1_other", 64'(issue_other), 1);
    check("order1_op", 64'(issue_op), 3);
`else
    check("order1_rob", 64'(issue_rob_id), 5);
    check("order1_v1", 64'(issue_v1), 64'h55);
    check("order1_other", 64'(issue_other), 1);
    check("order1_op", 64'(issue_op), 5);
`endif
    check("order1_type", 64'(issue_type), 64'(OPC_R));
    tick(); idle(); #1;
    check("accept_fire_count", 64'(count), 2);
`ifdef RS_WAKE_BYPASS_EN
    check("order2_rob", 64'(issue_rob_id), 5);
    check("order2_v1_stale_tag", 64'(issue_v1), 64'h55);
`else
    check("order2_rob", 64'(issue_rob_id), 3);
    check("order2_v1", 64'(issue_v1), 64'h10);
    check("order2_v2", 64'(issue_v2), 64'h22);
`endif
    tick(); #1;
    check("order3_rob", 64'(issue_rob_id), 7);
    check("order3_v1_no_capture", 64'(issue_v1), 64'h77);
    check("order3_count", 64'(count), 1);
    tick(); #1;
    check("order_empty_count", 64'(count), 0);
    check("order_empty_valid", 64'(issue_valid), 0);

    // Dispatch capture from CDB1 in the same cycle
    disp(4'd9, 32'h0, 32'h5, 1'b1, 4'd6, 1'b0, 4'd0);
    cdb(1, 4'd6, 32'hDEAD); #1;
    check("capture_idle", 64'(issue_valid), 0);
    tick(); idle(); #1;
    check("capture_valid", 64'(issue_valid), 1);
    check("capture_rob", 64'(issue_rob_id), 9);
    check("capture_v1", 64'(issue_v1), 64'hDEAD);
    tick(); #1;
    check("capture_count", 64'(count), 0);

    // Dual CDB wake-up of both operands; same-cycle issue only with bypass
    issue_ready = 1'b0;
    disp(4'd4, 32'h0, 32'h0, 1'b1, 4'd2, 1'b1, 4'd4); tick();
    idle();
    cdb(0, 4'd2, 32'h7);
    cdb(1, 4'd4, 32'h9); #1;
`ifdef RS_WAKE_BYPASS_EN
    check("bypass_valid", 64'(issue_valid), 1);
    check("bypass_v1", 64'(issue_v1), 64'h7);
    check("bypass_v2", 64'(issue_v2), 64'h9);
`else
    check("nobypass_valid", 64'(issue_valid), 0);
`endif
    tick(); idle(); #1;
    check("dual_valid", 64'(issue_valid), 1);
    check("dual_v1", 64'(issue_v1), 64'h7);
    check("dual_v2", 64'(issue_v2), 64'h9);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;

    // Same tag on both ports: lowest port wins
    disp(4'd10, 32'h0, 32'hF, 1'b1, 4'd3, 1'b0, 4'd0); tick();
    idle();
    cdb(0, 4'd3, 32'hA);
    cdb(1, 4'd3, 32'hB);
    tick(); idle(); #1;
    check("port_prio_rob", 64'(issue_rob_id), 10);
    check("port_prio_v1", 64'(issue_v1), 64'hA);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0; #1;
    check("port_prio_count", 64'(count), 0);

    // rdy=0 holds everything, including wake-up and dispatch
    disp(4'd1, 32'h11, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0); tick();
    disp(4'd2, 32'h0, 32'h0, 1'b1, 4'd5, 1'b0, 4'd0); tick();
    idle();
    rdy = 1'b0;
    issue_ready = 1'b1;
    disp(4'd6, 32'h66, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0);
    cdb(0, 4'd5, 32'h99); #1;
    check("hold_issue_valid", 64'(issue_valid), 0);
    check("hold_disp_ready", 64'(disp_ready), 0);
    tick();
    rdy = 1'b1;
    idle();
    issue_ready = 1'b0; #1;
    check("hold_count", 64'(count), 2);
    check("hold_rob_after", 64'(issue_rob_id), 1);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0; #1;
    check("hold_no_wake", 64'(issue_valid), 0);
    check("hold_count_after", 64'(count), 1);

    // Flush mid-stream drops everything, including that cycle's dispatch/issue
    disp(4'd13, 32'h13, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0); tick();
    idle(); #1;
    check("preflush_valid", 64'(issue_valid), 1);
    flush = 1'b1;
    issue_ready = 1'b1;
    disp(4'd12, 32'h12, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    flush = 1'b0;
    issue_ready = 1'b0;
    idle(); #1;
    check("flush_count", 64'(count), 0);
    check("flush_issue_valid", 64'(issue_valid), 0);
    check("flush_disp_ready", 64'(disp_ready), 1);
    disp(4'd14, 32'hE0, 32'hE1, 1'b0, 4'd0, 1'b0, 4'd0); tick();
    idle(); #1;
    check("postflush_rob", 64'(issue_rob_id), 14);
    check("postflush_v1", 64'(issue_v1), 64'hE0);
    check("postflush_count", 64'(count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
